regfile_operand_stage: RTL and testbench
========================================

Name: regfile_operand_stage

Overview:
- Operand-issue stage directly upstream of the bitwise ALU slice array.
- Holds an NREGS x WIDTH register file and accepts commands of the form (rs1, rs2, rd, oper).
- Reads both source operands, applies write-back bypass and a per-register busy scoreboard, then presents registered operands (a, b, oper) to the ALU over a valid/ready handshake.
- Takes ALU results back on a single write port.

Parameters:
- WIDTH, 8: data width of each register and operand.
- NREGS, 8: number of registers. Must be a power of two, at least 2.
- AW, 3: address width, equal to log2(NREGS).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  stage accepts the command this cycle.
- cmd_rs1  in  AW  source register for operand a.
- cmd_rs2  in  AW  source register for operand b.
- cmd_rd  in  AW  destination register, carried with the operands.
- cmd_oper  in  1  ALU select: 0 = AND, 1 = OR. Passed through unchanged.
- wr_en  in  1  write-back strobe from the ALU output side.
- wr_addr  in  AW  write-back register.
- wr_data  in  WIDTH  write-back value.
- out_valid  out  1  operands valid toward the ALU.
- out_ready  in  1  ALU side accepts the operands.
- out_a  out  WIDTH  operand a.
- out_b  out  WIDTH  operand b.
- out_oper  out  1  registered oper.
- out_rd  out  AW  registered destination.

Behaviour:
- Reset: on rst=1 at a rising edge, the following are cleared to 0:
  - all registers;
  - all busy bits;
  - out_valid, out_a, out_b, out_oper and out_rd.
- Reset mid-operation: any held output and any pending scoreboard entries are discarded. cmd_ready is combinational and is therefore 1 in the first cycle after reset.
- Register 0: always reads 0. Writes to it are ignored, and its busy bit is never set.
- Write port: when wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data at the edge and busy[wr_addr] is cleared, unless the same edge sets it again (see issue rule).
- Source readiness: source register r is ready when any of the following holds:
  - r==0;
  - busy[r]==0;
  - wr_en=1 and wr_addr==r (bypass case).
- Stall: stall = cmd_valid and (rs1 not ready, or rs2 not ready, or rd not ready). Readiness of rd uses the same rule, so a pending write to rd is never overtaken (WAW).
- Handshake: cmd_ready = !stall and (!out_valid or out_ready). The command is accepted when cmd_valid and cmd_ready are both 1.
- Operand capture on accept:
  - out_a = bypass ? wr_data : reg[rs1], with the same rule for out_b and rs2;
  - rs==0 always gives 0, even when wr_addr==0;
  - out_oper and out_rd are captured;
  - out_valid is set to 1.
- Scoreboard on accept: busy[rd] is set when rd!=0. If a write-back clears and an accept sets the same register at the same edge, set wins and busy stays 1.
- Output hold: while out_valid=1 and out_ready=0, out_a, out_b, out_oper and out_rd hold stable.
- Output drain: if out_ready=1 with no new accept, out_valid falls to 0 at the edge and the data outputs keep their last values.
- Latency and throughput: one cycle from accept to out_valid. Back-to-back accepts give full throughput when no hazards are present.
- Width: all data paths are WIDTH bits, with no extension or truncation. Addresses wrap naturally at NREGS.
- Simultaneous accept and drain: when the held output drains and a new command is accepted in the same cycle, the new operands replace the old ones with out_valid staying 1.

Test Plan:
- Reset, then a write-back sequence: wr 1<-0x3C, then wr 2<-0xA5; issue (rs1=1, rs2=2, rd=3, oper=0) with out_ready=1.
  - Required: out_a=0x3C, out_b=0xA5, out_oper=0, out_rd=3, out_valid=1 one cycle after accept.
  - Required: busy[3]=1.
- RAW stall: with busy[3] set, issue rs1=3.
  - Required: cmd_ready=0 for every cycle until wr_en with wr_addr=3, wr_data=0x81.
  - Required: in that cycle cmd_ready=1 and out_a=0x81 through the bypass.
- Back-pressure: out_ready=0 for 4 cycles with out_valid=1.
  - Required: outputs stable and cmd_ready=0.
  - Then out_ready=1 with a new command pending: the new operands load in the same edge and out_valid stays 1.
- Register 0: write 0xFF to reg 0, then issue rs1=0, rs2=0, rd=0.
  - Required: out_a=out_b=0 and no busy bit set.
  - Required: an immediately following command using rd=0 does not stall.
- WAW and same-edge set/clear: issue rd=5; then in the cycle that wr_en writes reg 5 (wr_data=0x11), accept a command with rd=5.
  - Required: busy[5] remains 1 and reg[5]=0x11.
- Reset mid-operation: with out_valid=1 and busy[4]=1, assert rst for one cycle.
  - Required: out_valid=0, all registers read 0, and a command with rs1=4 is accepted immediately.

Source files
------------

// File: rtl/regfile_operand_stage.sv
// Operand-issue stage: register file, write-back bypass, busy scoreboard and
// a single registered output slot feeding the bitwise ALU over valid/ready.
module regfile_operand_stage #(
    parameter int WIDTH = 8,
    parameter int NREGS = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [AW-1:0]    cmd_rs1,
    input  logic [AW-1:0]    cmd_rs2,
    input  logic [AW-1:0]    cmd_rd,
    input  logic             cmd_oper,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             out_oper,
    output logic [AW-1:0]    out_rd
);

    logic [WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;

    logic             wr_live;
    logic             rs1_ready;
    logic             rs2_ready;
    logic             rd_ready;
    logic             stall;
    logic             accept;
    logic [WIDTH-1:0] rs1_value;
    logic [WIDTH-1:0] rs2_value;

    // Source readiness and bypassed operand values; register 0 is hardwired to zero
    always_comb begin
        wr_live   = wr_en && (wr_addr != '0);
        rs1_ready = (cmd_rs1 == '0) || !busy[cmd_rs1] || (wr_en && (wr_addr == cmd_rs1));
        rs2_ready = (cmd_rs2 == '0) || !busy[cmd_rs2] || (wr_en && (wr_addr == cmd_rs2));
        rd_ready  = (cmd_rd  == '0) || !busy[cmd_rd]  || (wr_en && (wr_addr == cmd_rd));
        stall     = cmd_valid && !(rs1_ready && rs2_ready && rd_ready);
        cmd_ready = !stall && (!out_valid || out_ready);
        accept    = cmd_valid && cmd_ready;

        rs1_value = regs[cmd_rs1];
        if (cmd_rs1 == '0) begin
            rs1_value = '0;
        end else if (wr_en && (wr_addr == cmd_rs1)) begin
            rs1_value = wr_data;
        end

        rs2_value = regs[cmd_rs2];
        if (cmd_rs2 == '0) begin
            rs2_value = '0;
        end else if (wr_en && (wr_addr == cmd_rs2)) begin
            rs2_value = wr_data;
        end
    end

    // Register file write port; register 0 is never written
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Busy scoreboard: write-back clears, accept sets, and set wins on the same register
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (wr_live) begin
                busy[wr_addr] <= 1'b0;
            end
            if (accept && (cmd_rd != '0)) begin
                busy[cmd_rd] <= 1'b1;
            end
        end
    end

    // Output slot: load on accept, drop valid on drain, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_oper  <= 1'b0;
            out_rd    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_a     <= rs1_value;
            out_b     <= rs2_value;
            out_oper  <= cmd_oper;
            out_rd    <= cmd_rd;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_operand_stage.sv
// Self-checking bench for regfile_operand_stage: directed vectors, a
// per-cycle behavioural model comparison and hand-computed literal checks.
module tb_regfile_operand_stage;

    localparam int WIDTH = 8;
    localparam int NREGS = 8;
    localparam int AW    = 3;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [AW-1:0]    cmd_rs1;
    logic [AW-1:0]    cmd_rs2;
    logic [AW-1:0]    cmd_rd;
    logic             cmd_oper;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic             out_oper;
    logic [AW-1:0]    out_rd;

    int pass_count  = 0;
    int check_count = 0;

    regfile_operand_stage #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rs1   (cmd_rs1),
        .cmd_rs2   (cmd_rs2),
        .cmd_rd    (cmd_rd),
        .cmd_oper  (cmd_oper),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_oper  (out_oper),
        .out_rd    (out_rd)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state: architectural registers, pending writes, output slot
    logic [WIDTH-1:0] m_regs [NREGS];
    logic [NREGS-1:0] m_busy;
    logic             m_valid;
    logic [WIDTH-1:0] m_a;
    logic [WIDTH-1:0] m_b;
    logic             m_oper;
    logic [AW-1:0]    m_rd;
    bit               started = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit src_ok(input logic [AW-1:0] r);
        return (r == 0) || !m_busy[r] || (wr_en && wr_addr == r);
    endfunction

    function automatic logic [WIDTH-1:0] src_val(input logic [AW-1:0] r);
        if (r == 0) return '0;
        if (wr_en && wr_addr == r) return wr_data;
        return m_regs[r];
    endfunction

    function automatic bit model_ready();
        bit hazard;
        hazard = cmd_valid && !(src_ok(cmd_rs1) && src_ok(cmd_rs2) && src_ok(cmd_rd));
        return !hazard && (!m_valid || out_ready);
    endfunction

    // Model update on every rising edge from the pre-edge inputs
    always @(posedge clk) begin
        bit acc;
        if (rst) begin
            for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
            m_busy  = '0;
            m_valid = 1'b0;
            m_a     = '0;
            m_b     = '0;
            m_oper  = 1'b0;
            m_rd    = '0;
            started = 1;
        end else if (started) begin
            acc = cmd_valid && model_ready();
            if (acc) begin
                m_valid = 1'b1;
                m_a     = src_val(cmd_rs1);
                m_b     = src_val(cmd_rs2);
                m_oper  = cmd_oper;
                m_rd    = cmd_rd;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (wr_en && wr_addr != 0) begin
                m_regs[wr_addr] = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (acc && cmd_rd != 0) m_busy[cmd_rd] = 1'b1;
        end
    end

    // Compare DUT against the model on every falling edge once reset has been seen
    always @(negedge clk) begin
        if (started) begin
            checkOutput("cmd_ready", {31'b0, cmd_ready}, {31'b0, model_ready()});
            checkOutput("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
            checkOutput("out_a", {24'b0, out_a}, {24'b0, m_a});
            checkOutput("out_b", {24'b0, out_b}, {24'b0, m_b});
            checkOutput("out_oper", {31'b0, out_oper}, {31'b0, m_oper});
            checkOutput("out_rd", {29'b0, out_rd}, {29'b0, m_rd});
            checkOutput("busy", {24'b0, dut.busy}, {24'b0, m_busy});
            for (int i = 0; i < NREGS; i++) begin
                checkOutput($sformatf("reg%0d", i), {24'b0, dut.regs[i]}, {24'b0, m_regs[i]});
            end
        end
    end

    // Drive one cycle worth of inputs just after the rising edge
    task automatic applyStimulus(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                                 input logic [AW-1:0] rd, input logic op, input logic we,
                                 input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd, input logic ordy);
        cmd_valid = v;
        cmd_rs1   = rs1;
        cmd_rs2   = rs2;
        cmd_rd    = rd;
        cmd_oper  = op;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        out_ready = ordy;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Watchdog so the run always ends
    initial begin
        #20000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("%0d/%0d checks passed", pass_count, check_count + 1);
        $fatal(1, "[TB] timeout");
    end

    // Directed scenario sequence
    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 8'h00, 1);
        nextCycle();
        nextCycle();
        rst = 1'b0;
        #1;
        checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset cmd_ready", {31'b0, cmd_ready}, 32'd1);
        checkOutput("reset out_a", {24'b0, out_a}, 32'd0);

        // Write-back sequence then a clean issue
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 8'h3C, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 1, 2, 8'hA5, 1);
        nextCycle();
        applyStimulus(1, 1, 2, 3, 0, 0, 0, 8'h00, 1);
        checkOutput("issue cmd_ready", {31'b0, cmd_ready}, 32'd1);
        nextCycle();
        checkOutput("issue out_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("issue out_a", {24'b0, out_a}, 32'h3C);
        checkOutput("issue out_b", {24'b0, out_b}, 32'hA5);
        checkOutput("issue out_oper", {31'b0, out_oper}, 32'd0);
        checkOutput("issue out_rd", {29'b0, out_rd}, 32'd3);

        // RAW stall on r3 until the write-back bypass releases it
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 3, 1, 4, 1, 0, 0, 8'h00, 1);
            checkOutput("raw stall", {31'b0, cmd_ready}, 32'd0);
            nextCycle();
        end
        applyStimulus(1, 3, 1, 4, 1, 1, 3, 8'h81, 1);
        checkOutput("raw release", {31'b0, cmd_ready}, 32'd1);
        nextCycle();
        checkOutput("bypass out_a", {24'b0, out_a}, 32'h81);
        checkOutput("bypass out_b", {24'b0, out_b}, 32'h3C);
        checkOutput("bypass out_rd", {29'b0, out_rd}, 32'd4);

        // Back-pressure for four cycles, then drain and reload on the same edge
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 2, 6, 0, 0, 0, 8'h00, 0);
            checkOutput("bp cmd_ready", {31'b0, cmd_ready}, 32'd0);
            checkOutput("bp out_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("bp out_a", {24'b0, out_a}, 32'h81);
            nextCycle();
        end
        applyStimulus(1, 1, 2, 6, 0, 0, 0, 8'h00, 1);
        checkOutput("bp release", {31'b0, cmd_ready}, 32'd1);
        nextCycle();
        checkOutput("reload out_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("reload out_a", {24'b0, out_a}, 32'h3C);
        checkOutput("reload out_rd", {29'b0, out_rd}, 32'd6);

        // Register 0: writes ignored, reads zero even with a live write to r0
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 8'hFF, 1);
        nextCycle();
        applyStimulus(1, 0, 0, 0, 1, 1, 0, 8'hFF, 1);
        checkOutput("r0 cmd_ready", {31'b0, cmd_ready}, 32'd1);
        nextCycle();
        checkOutput("r0 out_a", {24'b0, out_a}, 32'd0);
        checkOutput("r0 out_b", {24'b0, out_b}, 32'd0);
        checkOutput("r0 out_valid", {31'b0, out_valid}, 32'd1);
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 8'h00, 1);
        checkOutput("r0 no stall", {31'b0, cmd_ready}, 32'd1);
        nextCycle();
        checkOutput("r0 follow out_b", {24'b0, out_b}, 32'h3C);
        checkOutput("r0 busy", {31'b0, dut.busy[0]}, 32'd0);

        // WAW stall and same-edge clear/set on r5
        applyStimulus(1, 1, 2, 5, 0, 0, 0, 8'h00, 1);
        nextCycle();
        applyStimulus(1, 0, 0, 5, 1, 0, 0, 8'h00, 1);
        checkOutput("waw stall", {31'b0, cmd_ready}, 32'd0);
        nextCycle();
        applyStimulus(1, 0, 0, 5, 1, 1, 5, 8'h11, 1);
        checkOutput("waw release", {31'b0, cmd_ready}, 32'd1);
        nextCycle();
        checkOutput("waw busy5", {31'b0, dut.busy[5]}, 32'd1);
        checkOutput("waw reg5", {24'b0, dut.regs[5]}, 32'h11);
        applyStimulus(1, 5, 0, 1, 0, 0, 0, 8'h00, 1);
        checkOutput("waw raw stall", {31'b0, cmd_ready}, 32'd0);
        nextCycle();

        // Reset mid-operation with a held output and r4 still busy
        applyStimulus(1, 1, 1, 7, 0, 0, 0, 8'h00, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 8'h00, 0);
        checkOutput("pre-reset out_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("pre-reset busy4", {31'b0, dut.busy[4]}, 32'd1);
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        applyStimulus(1, 4, 1, 1, 0, 0, 0, 8'h00, 1);
        checkOutput("post-reset out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("post-reset cmd_ready", {31'b0, cmd_ready}, 32'd1);
        nextCycle();
        checkOutput("post-reset out_a", {24'b0, out_a}, 32'd0);
        checkOutput("post-reset out_b", {24'b0, out_b}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 8'h00, 1);
        nextCycle();
        nextCycle();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
